// File: rtl/jump_sequencer_pkg.sv
// Shared definitions for the fetch-address sequencer: field widths, state
// encoding and the PC-relative branch target helper.
package jump_sequencer_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned JOFF_W = 12;
    localparam int unsigned BOFF_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [PC_W-1:0] PC_STEP = 16'h0002;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_JSHADOW = 2'b01,
        ST_BSHADOW = 2'b10
    } seq_state_e;

    // Branch target is relative to the instruction after the branch; wraps mod 2^16.
    function automatic logic [PC_W-1:0] branch_target(
        input logic [PC_W-1:0]   bpc,
        input logic [BOFF_W-1:0] boff
    );
        return bpc + PC_STEP + {{(PC_W-BOFF_W-1){boff[BOFF_W-1]}}, boff, 1'b0};
    endfunction

endpackage

// File: rtl/jump_target_gen.sv
// Absolute jump target: keeps the top PC segment and replaces the rest with
// the word-aligned jump field.
module jump_target_gen
    import jump_sequencer_pkg::*;
(
    input  logic [PC_W-1:0]   jump_pc,
    input  logic [JOFF_W-1:0] jump_offset,
    output logic [PC_W-1:0]   target
);

    localparam int unsigned SEG_W = PC_W - JOFF_W - 1;

    logic unused_pc_low_s;

    assign unused_pc_low_s = ^jump_pc[PC_W-SEG_W-1:0];
    assign target          = {jump_pc[PC_W-1 -: SEG_W], jump_offset, 1'b0};

endmodule

// File: rtl/jump_sequencer.sv
// Fetch PC sequencer: sequential fetch, jump/branch redirects, and squash
// shadows after a redirect during which wrong-path requests are ignored.
module jump_sequencer
    import jump_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC      = 16'h0000,
    parameter int unsigned     BRANCH_SHADOW = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump_req,
    input  logic [PC_W-1:0]   jump_pc,
    input  logic [JOFF_W-1:0] jump_offset,
    input  logic              branch_req,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_pc,
    input  logic [BOFF_W-1:0] branch_offset,
    output logic [PC_W-1:0]   pc,
    output logic              flush_if,
    output logic              flush_id,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(BRANCH_SHADOW - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             flush_if_q, flush_if_d;
    logic             flush_id_q, flush_id_d;
    logic [PC_W-1:0]  jump_target_s;
    logic [PC_W-1:0]  branch_target_s;
    logic             branch_take_s;

    jump_target_gen u_jump_target_gen (
        .jump_pc     (jump_pc),
        .jump_offset (jump_offset),
        .target      (jump_target_s)
    );

    assign branch_target_s = branch_target(branch_pc, branch_offset);
    assign branch_take_s   = branch_req & branch_taken;

    // Next-state, next-PC and flush decisions; a stall freezes everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        flush_if_d = 1'b0;
        flush_id_d = 1'b0;
        if (stall) begin
            state_d = state_q;
            pc_d    = pc_q;
        end else begin
            case (state_q)
                ST_RUN, ST_JSHADOW: begin
                    if (branch_take_s) begin
                        // Older branch beats a same-cycle jump.
                        pc_d       = branch_target_s;
                        flush_if_d = 1'b1;
                        flush_id_d = 1'b1;
                        cnt_d      = SHADOW_LOAD;
                        state_d    = ST_BSHADOW;
                    end else if (jump_req && (state_q == ST_RUN)) begin
                        pc_d       = jump_target_s;
                        flush_if_d = 1'b1;
                        state_d    = ST_JSHADOW;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_RUN;
                    end
                end
                ST_BSHADOW: begin
                    pc_d = pc_q + PC_STEP;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_RUN;
                        cnt_d   = cnt_q;
                    end else begin
                        state_d = ST_BSHADOW;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    pc_d    = pc_q + PC_STEP;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, counter, PC and flush registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= {CNT_W{1'b0}};
            pc_q       <= RESET_PC;
            flush_if_q <= 1'b0;
            flush_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            flush_if_q <= flush_if_d;
            flush_id_q <= flush_id_d;
        end
    end

    assign pc       = pc_q;
    assign flush_if = flush_if_q;
    assign flush_id = flush_id_q;
    assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: directed vector table, hand-written stall/reset
// sequences, then random traffic against a behavioural model.
module tb_jump_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          SHADOW = 2;

    logic        clock = 1'b0;
    logic        reset, stall, jump_req, branch_req, branch_taken;
    logic [15:0] jump_pc, branch_pc, pc;
    logic [11:0] jump_offset;
    logic [7:0]  branch_offset;
    logic        flush_if, flush_id, busy;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: squash windows counted in remaining cycles.
    logic [15:0] m_pc;
    int          m_bsq;
    bit          m_jsq;
    logic        m_fif, m_fid;

    typedef struct {
        logic        r, s, jr;
        logic [15:0] jp;
        logic [11:0] jo;
        logic        br, bt;
        logic [15:0] bp;
        logic [7:0]  bo;
        logic [15:0] e_pc;
        logic        e_fif, e_fid, e_busy;
    } vec_t;

    vec_t tbl[$];

    jump_sequencer #(.RESET_PC(RST_PC), .BRANCH_SHADOW(SHADOW)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .jump_req      (jump_req),
        .jump_pc       (jump_pc),
        .jump_offset   (jump_offset),
        .branch_req    (branch_req),
        .branch_taken  (branch_taken),
        .branch_pc     (branch_pc),
        .branch_offset (branch_offset),
        .pc            (pc),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic model_step();
        int t;
        m_fif = 1'b0;
        m_fid = 1'b0;
        if (reset) begin
            m_pc  = RST_PC;
            m_bsq = 0;
            m_jsq = 1'b0;
        end else if (!stall) begin
            if (m_bsq > 0) begin
                m_bsq = m_bsq - 1;
                m_pc  = m_pc + 16'd2;
            end else if (branch_req && branch_taken) begin
                t     = int'(branch_pc) + 2 + 2 * int'($signed(branch_offset));
                m_pc  = t[15:0];
                m_fif = 1'b1;
                m_fid = 1'b1;
                m_bsq = SHADOW;
                m_jsq = 1'b0;
            end else if (jump_req && !m_jsq) begin
                t     = (int'(jump_pc) & 32'hE000) | ((int'(jump_offset) * 2) & 32'h1FFF);
                m_pc  = t[15:0];
                m_fif = 1'b1;
                m_jsq = 1'b1;
            end else begin
                m_pc  = m_pc + 16'd2;
                m_jsq = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic r, s, jr, input logic [15:0] jp, input logic [11:0] jo,
                       input logic br, bt, input logic [15:0] bp, input logic [7:0] bo);
        reset = r; stall = s; jump_req = jr; jump_pc = jp; jump_offset = jo;
        branch_req = br; branch_taken = bt; branch_pc = bp; branch_offset = bo;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle(input logic s);
        cyc(1'b0, s, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic check(input string name, input logic [15:0] e_pc,
                         input logic e_fif, e_fid, e_busy);
        n_total++;
        if ({pc, flush_if, flush_id, busy} === {e_pc, e_fif, e_fid, e_busy}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h fif=%b fid=%b busy=%b, want pc=%h fif=%b fid=%b busy=%b",
                     name, pc, flush_if, flush_id, busy, e_pc, e_fif, e_fid, e_busy);
        end
    endtask

    task automatic row(input logic r, s, jr, input logic [15:0] jp, input logic [11:0] jo,
                       input logic br, bt, input logic [15:0] bp, input logic [7:0] bo,
                       input logic [15:0] e_pc, input logic e_fif, e_fid, e_busy);
        vec_t v;
        v.r = r; v.s = s; v.jr = jr; v.jp = jp; v.jo = jo;
        v.br = br; v.bt = bt; v.bp = bp; v.bo = bo;
        v.e_pc = e_pc; v.e_fif = e_fif; v.e_fid = e_fid; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    initial begin
        idle(1'b0);
        //   r     s     jr    jp        jo       br    bt    bp        bo       pc        fif   fid   busy
        row(1'b1, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0000, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0002, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0004, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0006, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0008, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b1, 16'hE010, 12'hB8F, 1'b0, 1'b0, 16'h0000, 8'h00,   16'hF71E, 1'b1, 1'b0, 1'b1);
        row(1'b0, 1'b0, 1'b1, 16'hE010, 12'hB8F, 1'b0, 1'b0, 16'h0000, 8'h00,   16'hF720, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'hF722, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b1, 16'h0040, 8'hFC,   16'h003A, 1'b1, 1'b1, 1'b1);
        row(1'b0, 1'b0, 1'b1, 16'hE010, 12'hB8F, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h003C, 1'b0, 1'b0, 1'b1);
        row(1'b0, 1'b0, 1'b1, 16'hE010, 12'hB8F, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h003E, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0040, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b1, 16'hE010, 12'hB8F, 1'b1, 1'b1, 16'h0040, 8'hFC,   16'h003A, 1'b1, 1'b1, 1'b1);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h003C, 1'b0, 1'b0, 1'b1);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h003E, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 16'h0040, 8'hFC,   16'h0040, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b1, 16'hFFF0, 8'h10,   16'h0012, 1'b1, 1'b1, 1'b1);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0014, 1'b0, 1'b0, 1'b1);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0016, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b1, 16'hFFFA, 8'h00,   16'hFFFC, 1'b1, 1'b1, 1'b1);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'hFFFE, 1'b0, 1'b0, 1'b1);
        row(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0000, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b1, 1'b1, 16'hE010, 12'hB8F, 1'b0, 1'b0, 16'h0000, 8'h00,   16'h0000, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 1'b1, 16'hE010, 12'hB8F, 1'b0, 1'b0, 16'h0000, 8'h00,   16'hF71E, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].jr, tbl[i].jp, tbl[i].jo,
                tbl[i].br, tbl[i].bt, tbl[i].bp, tbl[i].bo);
            check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fif, tbl[i].e_fid, tbl[i].e_busy);
        end

        // Stall in the jump shadow: frozen, then the shadow completes.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0000, 12'h123, 1'b0, 1'b0, 16'h0000, 8'h00);
            check($sformatf("jshadow_stall%0d", i), 16'hF71E, 1'b0, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h0000, 12'h123, 1'b0, 1'b0, 16'h0000, 8'h00);
        check("jshadow_release", 16'hF720, 1'b0, 1'b0, 1'b0);

        // Reset mid branch shadow, with stall and a jump also asserted.
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b1, 16'h0040, 8'hFC);
        check("bshadow_enter", 16'h003A, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'hE010, 12'hB8F, 1'b1, 1'b1, 16'h0040, 8'hFC);
        check("reset_mid_shadow", RST_PC, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        check("post_reset_stall", RST_PC, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("post_reset_first", RST_PC + 16'd2, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), 16'($urandom), 12'($urandom),
                ($urandom_range(0, 2) == 0), 1'($urandom), 16'($urandom), 8'($urandom));
            check($sformatf("rand%0d", i), m_pc, m_fif, m_fid, (m_bsq > 0) || m_jsq);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jump_sequencer.md
JUMP_SEQUENCER -- requirements
Module: jump_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter BRANCH_SHADOW, default 2, SHALL be the number of cycles during which requests are squashed after a taken branch.
REQ-003 clock  input  1  SHALL be the single rising-edge clock.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 stall  input  1  SHALL be the hazard-unit freeze; while it is high, PC and state hold.
REQ-006 jump_req  input  1  SHALL indicate that the decode stage holds an unconditional jump.
REQ-007 jump_pc  input  16  SHALL be the address of the jump instruction.
REQ-008 jump_offset  input  12  SHALL be the raw jump field.
REQ-009 branch_req  input  1  SHALL indicate that the execute stage has resolved a branch.
REQ-010 branch_taken  input  1  SHALL be the branch outcome, valid with branch_req.
REQ-011 branch_pc  input  16  SHALL be the address of the branch instruction.
REQ-012 branch_offset  input  8  SHALL be the signed word offset.
REQ-013 pc  output  16  SHALL be the registered fetch address.
REQ-014 flush_if  output  1  SHALL be a registered pulse that kills the fetch-stage instruction.
REQ-015 flush_id  output  1  SHALL be a registered pulse that kills the decode-stage instruction.
REQ-016 busy  output  1  SHALL be high while the state is not RUN.

Function
REQ-017 States SHALL be RUN, JSHADOW and BSHADOW, held in a 2-bit encoding with an 8-bit-or-less shadow counter.
REQ-018 Jump target SHALL be {jump_pc[15:13], jump_offset, 1'b0}; the 12-bit offset is shifted left one bit and zero-filled, giving 13 bits.
REQ-019 Branch target SHALL be branch_pc + 2 + (sign-extended branch_offset << 1), computed modulo 2^16 with silent wrap.
REQ-020 In RUN with no accepted request, the next pc SHALL be pc + 2, wrapping from 16'hFFFE to 16'h0000.
REQ-021 When branch_req and branch_taken are both high and stall is low, the next pc SHALL be the branch target.
REQ-022 In that case, flush_if and flush_id SHALL be 1 for exactly one cycle, the counter SHALL load BRANCH_SHADOW-1, and the state SHALL go to BSHADOW.
REQ-023 When branch_req is high and branch_taken is low, the block SHALL take no action, and the pc + 2 sequence SHALL continue.
REQ-024 When jump_req is high in RUN, stall is low, and no taken branch occurs in the same cycle, the next pc SHALL be the jump target.
REQ-025 In that case, flush_if SHALL be 1 for one cycle and the state SHALL go to JSHADOW.
REQ-026 If a taken branch and jump_req occur in the same cycle, the branch SHALL win, since it is the older instruction, and the jump SHALL be dropped.
REQ-027 JSHADOW SHALL last one non-stalled cycle, then return to RUN; jump_req SHALL be ignored in this state.
REQ-028 In JSHADOW a taken branch SHALL still be honoured, following REQ-021 and REQ-022.
REQ-029 BSHADOW SHALL ignore jump_req and branch_req (wrong path) and SHALL decrement the counter on each non-stalled cycle.
REQ-030 BSHADOW SHALL return to RUN when the counter is 0; if BRANCH_SHADOW is 1, it SHALL return to RUN on the next cycle.
REQ-031 While stall is high, pc, state and counter SHALL hold, flush outputs SHALL be 0, and requests SHALL NOT be consumed; upstream holds them.
REQ-032 Redirect latency SHALL be 1 cycle: the target appears on pc at the clock edge after acceptance.

Reset
REQ-033 When reset is high at a clock edge, the block SHALL set pc=RESET_PC, state=RUN, counter=0, flush_if=0, flush_id=0 and busy=0.
REQ-034 Reset SHALL override stall and any pending request, including a reset asserted mid-shadow.
REQ-035 The first pc + 2 increment SHALL occur on the first non-stalled edge after reset deasserts.

Structure
REQ-036 The state encoding, the PC width (16), the jump field width (12) and the branch field width (8) SHALL be defined in the shared processor package.
REQ-037 A single sub-module, jump_target_gen, SHALL be instantiated for the combinational shift-and-concatenate target of REQ-018.
REQ-038 All other logic SHALL stay flat.

Verification
REQ-039 Reset then 4 free cycles -> pc = 0000, 0002, 0004, 0006, 0008 with flushes 0.
REQ-040 jump_req=1, jump_pc=16'hE010, jump_offset=12'hB8F -> next pc = 16'hF71E, flush_if=1 for 1 cycle, busy=1 for 1 cycle.
REQ-041 Taken branch, branch_pc=16'h0040, branch_offset=8'hFC -> next pc = 16'h003A, both flushes 1, and a jump_req in the following 2 cycles is ignored.
REQ-042 Taken branch and jump_req in the same cycle -> pc = branch target, jump dropped.
REQ-043 stall=1 for 3 cycles during JSHADOW -> pc and busy frozen, flushes 0; JSHADOW completes after the stall is released.
REQ-044 pc=16'hFFFE with a free cycle -> 16'h0000; branch_pc=16'hFFF0, branch_offset=8'h10 -> 16'h0012; reset asserted mid-BSHADOW -> RESET_PC, busy=0.
